// File: rtl/muldiv_hilo_ctrl.sv
//==============================================================================
// Module   : muldiv_hilo_ctrl
// Brief    : Pipeline-side controller for the 32-cycle sequential multDiv unit.
//            Launches MULTU/DIVU with a one-cycle valid pulse, tracks the busy
//            window, owns architectural HI/LO, stalls early dependent or
//            conflicting ops, and bypasses the result on the ready cycle.
// Options  : MULDIV_DIVZERO_EN - DIVU by zero completes locally in IDLE
//            (HI = dividend, LO = all ones) without launching the unit.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_hilo_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] HILO_RST = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [1:0]          op_code,
    input  logic [XLEN-1:0]     rs_data,
    input  logic [XLEN-1:0]     rt_data,
    output logic                stall,
    output logic [XLEN-1:0]     rd_data,
    output logic                md_valid,
    output logic                md_mode,
    output logic [XLEN-1:0]     md_in_A,
    output logic [XLEN-1:0]     md_in_B,
    input  logic                md_ready,
    input  logic [2*XLEN-1:0]   md_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] w_hi_next;
    logic [XLEN-1:0] w_lo_next;
    logic            w_busy;
    logic            w_ready_hit;
    logic            w_accept_md;
    logic            w_launch;
    logic            w_hilo_wr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall generation, next-state decode, launch and HI/LO write requests
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        // The ready cycle frees the unit, so whatever op is waiting may go
        w_ready_hit  = (r_state == S_WAIT) && md_ready;
        stall        = op_valid && w_busy && !w_ready_hit;
        w_accept_md  = op_valid && !stall && !op_code[1];
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_hilo_wr    = 1'b0;
        w_hi_next    = md_out[2*XLEN-1:XLEN];
        w_lo_next    = md_out[XLEN-1:0];
        case (r_state)
            S_IDLE: begin
                if (w_accept_md) begin
`ifdef MULDIV_DIVZERO_EN
                    if (op_code[0] && (rt_data == '0)) begin
                        w_hilo_wr = 1'b1;
                        w_hi_next = rs_data;
                        w_lo_next = '1;
                    end else begin
                        w_launch     = 1'b1;
                        w_state_next = S_ISSUE;
                    end
`else
                    w_launch     = 1'b1;
                    w_state_next = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (md_ready) begin
                    w_hilo_wr = 1'b1;
                    // Unit is in its OUT state now and idle next cycle,
                    // so a new launch here is legal
                    if (w_accept_md) begin
                        w_launch     = 1'b1;
                        w_state_next = S_ISSUE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Launch registers: valid pulse lasts exactly the ISSUE cycle, operands hold
    always_ff @(posedge clk) begin
        if (rst) begin
            md_valid <= 1'b0;
            md_mode  <= 1'b0;
            md_in_A  <= '0;
            md_in_B  <= '0;
        end else begin
            md_valid <= w_launch;
            if (w_launch) begin
                md_mode <= op_code[0];
                md_in_A <= rs_data;
                md_in_B <= rt_data;
            end
        end
    end

    // Architectural HI/LO capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= HILO_RST;
            r_lo <= HILO_RST;
        end else if (w_hilo_wr) begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
        end
    end

    // MFHI/MFLO read path with same-cycle bypass of the unit result
    always_comb begin
        rd_data = '0;
        if (op_valid && op_code[1]) begin
            if (op_code[0]) begin
                rd_data = w_ready_hit ? md_out[XLEN-1:0] : r_lo;
            end else begin
                rd_data = w_ready_hit ? md_out[2*XLEN-1:XLEN] : r_hi;
            end
        end
    end

endmodule

`default_nettype wire
